spi_matrix_receiver: RTL and testbench



---
 rtl/spi_matrix_receiver.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_spi_matrix_receiver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_matrix_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_matrix_receiver
//
// Word-level ingest stage for the matrix-multiply datapath. Pulls 32-bit words
// from the spi_slave receive channel, parses a header (rows in [31:16], cols in
// [15:0]) followed by the row-major elements of operand A, then does the same
// for operand B. Both operands are held in flat buffers together with their
// dimensions; done_rx pulses once when both are complete and consistent.
//
// Optional build macro: SPI_RX_CHECKSUM_EN
//   When defined, one extra word follows the B elements. It must equal the XOR
//   of every A and B element word (headers excluded), otherwise the transfer
//   ends in ERROR with err_code=4.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   rx_data/rx_valid   word offered by the spi_slave receive channel
//   rx_ready           a word is consumed on any edge with rx_valid && rx_ready
//   start_rx           begin a new two-operand reception (honoured in IDLE only)
//   matrix_A/matrix_B  operand buffers, element (r,c) at index r*cols+c
//   A_rows..B_cols     dimensions latched from the accepted headers
//   busy               high whenever the receiver is not idle
//   done_rx            single-cycle pulse, both operands received
//   err, err_code      sticky error flag and cause (1: A header, 2: B header
//                      range, 3: B rows != A cols, 4: checksum mismatch)
// -----------------------------------------------------------------------------
module spi_matrix_receiver #(
   parameter int MAX_M = 10,
   parameter int MAX_N = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start_rx,
   output logic [31:0] matrix_A [MAX_M*MAX_N],
   output logic [31:0] matrix_B [MAX_M*MAX_N],
   output logic [15:0] A_rows,
   output logic [15:0] A_cols,
   output logic [15:0] B_rows,
   output logic [15:0] B_cols,
   output logic        busy,
   output logic        done_rx,
   output logic        err,
   output logic [2:0]  err_code
);

   localparam int DEPTH = MAX_M * MAX_N;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [15:0] LIM_M = 16'(MAX_M);
   localparam logic [15:0] LIM_N = 16'(MAX_N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_A,
      S_DATA_A,
      S_HDR_B,
      S_DATA_B,
`ifdef SPI_RX_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] index_reg, index_next;
   logic [15:0]      size_a_reg, size_a_next;
   logic [15:0]      size_b_reg, size_b_next;
   logic [15:0]      a_rows_reg, a_rows_next;
   logic [15:0]      a_cols_reg, a_cols_next;
   logic [15:0]      b_rows_reg, b_rows_next;
   logic [15:0]      b_cols_reg, b_cols_next;
   logic             err_reg, err_next;
   logic [2:0]       err_code_reg, err_code_next;
   // Cause chosen on the way into ERROR; published to err_code from ERROR.
   logic [2:0]       pend_code_reg, pend_code_next;
`ifdef SPI_RX_CHECKSUM_EN
   logic [31:0]      csum_reg, csum_next;
`endif

   logic [31:0]      mem_a [DEPTH];
   logic [31:0]      mem_b [DEPTH];

   logic             accept;
   logic [15:0]      hdr_rows;
   logic [15:0]      hdr_cols;
   logic [15:0]      hdr_size;
   logic             hdr_range_bad;
   logic [15:0]      index_inc;
   logic             last_a;
   logic             last_b;
   logic             wr_a;
   logic             wr_b;

   // ---------------------------------------------------------------------
   // Handshake and header decode
   // ---------------------------------------------------------------------
   always_comb begin
      rx_ready = 1'b0;
      case (state_reg)
         S_HDR_A, S_DATA_A, S_HDR_B, S_DATA_B: rx_ready = 1'b1;
`ifdef SPI_RX_CHECKSUM_EN
         S_CHK:                                rx_ready = 1'b1;
`endif
         default:                              rx_ready = 1'b0;
      endcase
   end

   assign accept        = rx_valid && rx_ready;
   assign hdr_rows      = rx_data[31:16];
   assign hdr_cols      = rx_data[15:0];
   assign hdr_size      = hdr_rows * hdr_cols;
   assign hdr_range_bad = (hdr_rows == 16'd0) || (hdr_cols == 16'd0) ||
                          (hdr_rows > LIM_M)  || (hdr_cols > LIM_N);

   // Element counter compared against the 16-bit operand size, so the
   // 1x1 case ends after its single element.
   assign index_inc = 16'(index_reg) + 16'd1;
   assign last_a    = (index_inc == size_a_reg);
   assign last_b    = (index_inc == size_b_reg);

   assign wr_a = (state_reg == S_DATA_A) && accept;
   assign wr_b = (state_reg == S_DATA_B) && accept;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      index_next     = index_reg;
      size_a_next    = size_a_reg;
      size_b_next    = size_b_reg;
      a_rows_next    = a_rows_reg;
      a_cols_next    = a_cols_reg;
      b_rows_next    = b_rows_reg;
      b_cols_next    = b_cols_reg;
      err_next       = err_reg;
      err_code_next  = err_code_reg;
      pend_code_next = pend_code_reg;
`ifdef SPI_RX_CHECKSUM_EN
      csum_next      = csum_reg;
`endif

      case (state_reg)
         S_IDLE: begin
            if (start_rx) begin
               err_next      = 1'b0;
               err_code_next = 3'd0;
               index_next    = '0;
`ifdef SPI_RX_CHECKSUM_EN
               csum_next     = '0;
`endif
               state_next    = S_HDR_A;
            end
         end

         S_HDR_A: begin
            if (accept) begin
               if (hdr_range_bad) begin
                  pend_code_next = 3'd1;
                  state_next     = S_ERROR;
               end else begin
                  a_rows_next = hdr_rows;
                  a_cols_next = hdr_cols;
                  size_a_next = hdr_size;
                  state_next  = S_DATA_A;
               end
            end
         end

         S_DATA_A: begin
            if (accept) begin
               if (last_a) begin
                  index_next = '0;
                  state_next = S_HDR_B;
               end else begin
                  index_next = index_reg + 1'b1;
               end
            end
         end

         S_HDR_B: begin
            // Range problems take precedence over the inner-dimension check.
            if (accept) begin
               if (hdr_range_bad) begin
                  pend_code_next = 3'd2;
                  state_next     = S_ERROR;
               end else if (hdr_rows != a_cols_reg) begin
                  pend_code_next = 3'd3;
                  state_next     = S_ERROR;
               end else begin
                  b_rows_next = hdr_rows;
                  b_cols_next = hdr_cols;
                  size_b_next = hdr_size;
                  state_next  = S_DATA_B;
               end
            end
         end

         S_DATA_B: begin
            if (accept) begin
               if (last_b) begin
                  index_next = '0;
`ifdef SPI_RX_CHECKSUM_EN
                  state_next = S_CHK;
`else
                  state_next = S_DONE;
`endif
               end else begin
                  index_next = index_reg + 1'b1;
               end
            end
         end

`ifdef SPI_RX_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (rx_data == csum_reg) begin
                  state_next = S_DONE;
               end else begin
                  pend_code_next = 3'd4;
                  state_next     = S_ERROR;
               end
            end
         end
`endif

         S_DONE: begin
            state_next = S_IDLE;
         end

         S_ERROR: begin
            err_next      = 1'b1;
            err_code_next = pend_code_reg;
            state_next    = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

`ifdef SPI_RX_CHECKSUM_EN
      // Running XOR over element words only; headers never pass wr_a/wr_b.
      if (wr_a || wr_b) begin
         csum_next = csum_reg ^ rx_data;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         index_reg     <= '0;
         size_a_reg    <= '0;
         size_b_reg    <= '0;
         a_rows_reg    <= '0;
         a_cols_reg    <= '0;
         b_rows_reg    <= '0;
         b_cols_reg    <= '0;
         err_reg       <= 1'b0;
         err_code_reg  <= 3'd0;
         pend_code_reg <= 3'd0;
`ifdef SPI_RX_CHECKSUM_EN
         csum_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         index_reg     <= index_next;
         size_a_reg    <= size_a_next;
         size_b_reg    <= size_b_next;
         a_rows_reg    <= a_rows_next;
         a_cols_reg    <= a_cols_next;
         b_rows_reg    <= b_rows_next;
         b_cols_reg    <= b_cols_next;
         err_reg       <= err_next;
         err_code_reg  <= err_code_next;
         pend_code_reg <= pend_code_next;
`ifdef SPI_RX_CHECKSUM_EN
         csum_reg      <= csum_next;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Operand storage: deliberately not reset, validity is signalled by
   // done_rx alone.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_a) begin
         mem_a[index_reg] <= rx_data;
      end
      if (wr_b) begin
         mem_b[index_reg] <= rx_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_out
         assign matrix_A[gi] = mem_a[gi];
         assign matrix_B[gi] = mem_b[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------
   assign A_rows   = a_rows_reg;
   assign A_cols   = a_cols_reg;
   assign B_rows   = b_rows_reg;
   assign B_cols   = b_cols_reg;
   assign busy     = (state_reg != S_IDLE);
   assign done_rx  = (state_reg == S_DONE);
   assign err      = err_reg;
   assign err_code = err_code_reg;

endmodule

// File: tb/tb_spi_matrix_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_matrix_receiver
//
// Table of directed two-operand transfers plus randomized transfers. Expected
// results come from a transfer-level model: the header rules decide the error
// cause, the word list to send, and which dimensions stay latched; the sent
// elements form the expected buffers.
// -----------------------------------------------------------------------------
module tb_spi_matrix_receiver;

   localparam int MAX_M = 10;
   localparam int MAX_N = 10;
   localparam int DEPTH = MAX_M * MAX_N;
   localparam logic [15:0] LIM_M = 16'(MAX_M);
   localparam logic [15:0] LIM_N = 16'(MAX_N);

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        start_rx;
   logic [31:0] matrix_A [DEPTH];
   logic [31:0] matrix_B [DEPTH];
   logic [15:0] A_rows, A_cols, B_rows, B_cols;
   logic        busy, done_rx, err;
   logic [2:0]  err_code;

   spi_matrix_receiver #(.MAX_M(MAX_M), .MAX_N(MAX_N)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .start_rx (start_rx),
      .matrix_A (matrix_A),
      .matrix_B (matrix_B),
      .A_rows   (A_rows),
      .A_cols   (A_cols),
      .B_rows   (B_rows),
      .B_cols   (B_cols),
      .busy     (busy),
      .done_rx  (done_rx),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_cnt     = 0;
   int acc_cnt      = 0;

   // Pre-edge values of the DUT outputs are seen here.
   always @(posedge clk) begin
      if (done_rx === 1'b1) done_cnt++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_cnt++;
   end

   // Model state: latched dims and expected buffers
   logic [15:0] m_ar, m_ac, m_br, m_bc;
   logic [31:0] exp_a [DEPTH];
   logic [31:0] exp_b [DEPTH];

   typedef struct {
      logic [31:0] ha;
      logic [31:0] hb;
      logic [31:0] a_base;
      logic [31:0] b_base;
      bit          rnd;
      bit          chk_bad;
      int          gap;      // 0 none, 1 idle cycle after each word, 2 random
      int          code;     // expected err_code (checksum build adjusts chk_bad)
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit dim_ok(input logic [15:0] r, input logic [15:0] c);
      return (r != 16'd0) && (c != 16'd0) && (r <= LIM_M) && (c <= LIM_N);
   endfunction

   // All tasks start and end right after a falling edge.
   task automatic start_pulse();
      start_rx = 1'b1;
      @(negedge clk);
      start_rx = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, output bit ok);
      ok       = 1'b0;
      rx_data  = w;
      rx_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (rx_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   task automatic run_txn(input string tag, input logic [31:0] ha, input logic [31:0] hb,
                          input logic [31:0] a_base, input logic [31:0] b_base,
                          input bit rnd, input bit chk_bad, input int gap, input int tbl_code);
      logic [31:0] words [$];
      logic [15:0] ar, ac, br, bc;
      logic [31:0] x, w;
      int code, expc, na, nb, d0, a0, bad;
      bit ok;
      ar = ha[31:16]; ac = ha[15:0];
      br = hb[31:16]; bc = hb[15:0];
      if (!dim_ok(ar, ac))      code = 1;
      else if (!dim_ok(br, bc)) code = 2;
      else if (br != ac)        code = 3;
      else                      code = 0;
      na = int'(ar) * int'(ac);
      nb = int'(br) * int'(bc);
      x  = '0;
      words.push_back(ha);
      if (code != 1) begin
         for (int k = 0; k < na; k++) begin
            w = rnd ? $urandom : a_base + 32'(k);
            exp_a[k] = w;
            x ^= w;
            words.push_back(w);
         end
         words.push_back(hb);
      end
      if (code == 0) begin
         for (int k = 0; k < nb; k++) begin
            w = rnd ? $urandom : b_base + 32'(k);
            exp_b[k] = w;
            x ^= w;
            words.push_back(w);
         end
`ifdef SPI_RX_CHECKSUM_EN
         words.push_back(chk_bad ? (x ^ 32'h1) : x);
         if (chk_bad) code = 4;
`endif
      end
      if (code != 1) begin
         m_ar = ar; m_ac = ac;
      end
      if (code == 0 || code == 4) begin
         m_br = br; m_bc = bc;
      end
      expc = (tbl_code < 0) ? code : tbl_code;
`ifdef SPI_RX_CHECKSUM_EN
      if (tbl_code == 0 && chk_bad) expc = 4;
`endif

      d0 = done_cnt;
      a0 = acc_cnt;
      start_pulse();
      check({tag, "_err_cleared"}, 32'(err), 32'd0);
      for (int i = 0; i < words.size(); i++) begin
         send_word(words[i], ok);
         if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: word %0d not accepted, required acceptance within 20 cycles", tag, i);
            break;
         end
         if (i == words.size() - 1) begin
            if (expc == 0) check({tag, "_done_latency"}, 32'(done_rx), 32'd1);
         end else if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
            @(negedge clk);
         end
      end
      repeat (3) @(negedge clk);

      $display("[TB] %s hdrA=%08h hdrB=%08h words=%0d exp_code=%0d got_code=%0d", tag, ha, hb, words.size(), expc, err_code);
      check({tag, "_err"},      32'(err),      (expc != 0) ? 32'd1 : 32'd0);
      check({tag, "_err_code"}, 32'(err_code), 32'(expc));
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt - d0), (expc == 0) ? 32'd1 : 32'd0);
      check({tag, "_accepted"}, 32'(acc_cnt - a0),  32'(words.size()));
      check({tag, "_A_rows"},   32'(A_rows), 32'(m_ar));
      check({tag, "_A_cols"},   32'(A_cols), 32'(m_ac));
      check({tag, "_B_rows"},   32'(B_rows), 32'(m_br));
      check({tag, "_B_cols"},   32'(B_cols), 32'(m_bc));
      if (expc == 0) begin
         bad = 0;
         for (int k = 0; k < na; k++) if (matrix_A[k] !== exp_a[k]) bad++;
         check({tag, "_matA_bad_elems"}, 32'(bad), 32'd0);
         bad = 0;
         for (int k = 0; k < nb; k++) if (matrix_B[k] !== exp_b[k]) bad++;
         check({tag, "_matB_bad_elems"}, 32'(bad), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      int a0;
      logic [15:0] ar, ac, br, bc;

      //           hdrA          hdrB          a_base b_base rnd chk gap code
      vecs[0]  = '{32'h00020003, 32'h00030002, 32'd1, 32'd7, 1'b0, 1'b0, 0, 0};
      vecs[1]  = '{32'h000B0002, 32'h00020002, 32'd1, 32'd1, 1'b0, 1'b0, 0, 1};
      vecs[2]  = '{32'h00020003, 32'h00020002, 32'd1, 32'd1, 1'b0, 1'b0, 0, 3};
      vecs[3]  = '{32'h00010001, 32'h00010001, 32'd5, 32'd3, 1'b0, 1'b0, 1, 0};
      vecs[4]  = '{32'h00010001, 32'h00010001, 32'd5, 32'd3, 1'b0, 1'b1, 0, 0};
      vecs[5]  = '{32'h000A000A, 32'h000A0001, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0};
      vecs[6]  = '{32'h00000003, 32'h00030001, 32'd1, 32'd1, 1'b0, 1'b0, 0, 1};
      vecs[7]  = '{32'h0003000B, 32'h000B0001, 32'd1, 32'd1, 1'b0, 1'b0, 0, 1};
      vecs[8]  = '{32'h00020003, 32'h00000002, 32'd1, 32'd1, 1'b0, 1'b0, 0, 2};
      vecs[9]  = '{32'h00020003, 32'h000B0003, 32'd1, 32'd1, 1'b0, 1'b0, 0, 2};
      vecs[10] = '{32'h00030001, 32'h00010000, 32'd1, 32'd1, 1'b0, 1'b0, 2, 2};
      vecs[11] = '{32'h000A0001, 32'h0001000A, 32'd0, 32'd0, 1'b1, 1'b0, 2, 0};

      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; start_rx = 1'b0;
      m_ar = '0; m_ac = '0; m_br = '0; m_bc = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_done",     32'(done_rx),  32'd0);
      check("rst_err",      32'(err),      32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_dims",     {A_rows, A_cols} | {B_rows, B_cols}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Words offered while idle stay in the slave.
      a0 = acc_cnt;
      rx_data = 32'h00010001; rx_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_rx_ready", 32'(rx_ready), 32'd0);
      check("idle_accepts",  32'(acc_cnt - a0), 32'd0);
      rx_valid = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].ha, vecs[i].hb, vecs[i].a_base, vecs[i].b_base,
                 vecs[i].rnd, vecs[i].chk_bad, vecs[i].gap, vecs[i].code);
      end

      // Reset in the middle of operand A.
      start_pulse();
      send_word(32'h00020003, ok);
      send_word(32'h00000011, ok);
      send_word(32'h00000022, ok);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_ar = '0; m_ac = '0; m_br = '0; m_bc = '0;
      $display("[TB] midrst reset during DATA_A busy=%0d A=%0dx%0d", busy, A_rows, A_cols);
      check("midrst_busy",     32'(busy),     32'd0);
      check("midrst_rx_ready", 32'(rx_ready), 32'd0);
      check("midrst_dims",     {A_rows, A_cols} | {B_rows, B_cols}, 32'd0);
      check("midrst_err",      32'(err),      32'd0);
      run_txn("after_rst", 32'h00020002, 32'h00020002, 32'd100, 32'd200, 1'b0, 1'b0, 0, 0);

      // Randomized transfers checked against the model.
      for (int i = 0; i < 40; i++) begin
         ar = 16'($urandom_range(0, 11));
         ac = 16'($urandom_range(0, 11));
         br = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 11)) : ac;
         bc = 16'($urandom_range(0, 11));
         run_txn($sformatf("rnd%0d", i), {ar, ac}, {br, bc}, 32'd0, 32'd0,
                 1'b1, bit'($urandom_range(0, 1)), 2, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
